// File: rtl/tone_period_meter.sv
// tone_period_meter: measures the period of an incoming square-wave tone in clk
// cycles (rising edge to rising edge) and flags whether it sits within TOL of
// TARGET_PERIOD; tone_locked asserts after LOCK_COUNT consecutive in-band periods.
// Optional macro TONE_DEGLITCH_EN inserts a 3-sample stability filter on the
// synchronized input so pulses of 1-2 cycles are ignored.
module tone_period_meter #(
    parameter int unsigned CNT_W         = 20,
    parameter int unsigned TIMEOUT       = 1048575,
    parameter int unsigned TARGET_PERIOD = 56818,
    parameter int unsigned TOL           = 568,
    parameter int unsigned LOCK_COUNT    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tone_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             in_band,
    output logic             tone_locked,
    output logic             timeout
);

    localparam int unsigned DW = CNT_W + 1;
    localparam int unsigned MW = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]     TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic signed [DW-1:0] TARGET_C  = $signed(DW'(TARGET_PERIOD));
    localparam logic [DW-1:0]        TOL_C     = DW'(TOL);
    localparam logic [MW-1:0]        LOCK_C    = MW'(LOCK_COUNT);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [MW-1:0]     match_cnt;
    logic              sync1;
    logic              sync2;
    logic              prev;
    logic              level;
    logic              rise;

    // Two-flop synchronizer for the asynchronous tone input
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= tone_in;
            sync2 <= sync1;
        end
    end

`ifdef TONE_DEGLITCH_EN
    logic [1:0] hist;
    logic       filt;

    // Filtered level follows sync2 only once it has held for 3 consecutive samples
    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= 2'b00;
            filt <= 1'b0;
        end else begin
            hist <= {hist[0], sync2};
            if ((sync2 == hist[0]) && (sync2 == hist[1])) begin
                filt <= sync2;
            end
        end
    end

    assign level = filt;
`else
    assign level = sync2;
`endif

    // Previous-level flop for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;

    logic signed [DW-1:0] diff;
    logic [DW-1:0]        abs_diff;
    logic                 in_band_c;
    logic [MW-1:0]        match_inc;
    logic                 lock_next_c;

    // Band check of the running count against the target, at CNT_W+1 bits signed
    always_comb begin
        diff      = $signed({1'b0, cnt}) - TARGET_C;
        abs_diff  = diff[DW-1] ? $unsigned(-diff) : $unsigned(diff);
        in_band_c = (abs_diff <= TOL_C);
    end

    // Saturating increment of the consecutive in-band counter
    always_comb begin
        match_inc   = (match_cnt == LOCK_C) ? match_cnt : match_cnt + MW'(1);
        lock_next_c = (match_inc == LOCK_C);
    end

    // Measurement FSM: count cycles between rises, report, track lock and timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            match_cnt    <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            in_band      <= 1'b0;
            tone_locked  <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rise) begin
                        cnt   <= CNT_W'(1);
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period       <= cnt;
                        period_valid <= 1'b1;
                        in_band      <= in_band_c;
                        cnt          <= CNT_W'(1);
                        if (in_band_c) begin
                            match_cnt   <= match_inc;
                            tone_locked <= lock_next_c;
                        end else begin
                            match_cnt   <= '0;
                            tone_locked <= 1'b0;
                        end
                    end else if (cnt == TIMEOUT_C) begin
                        timeout     <= 1'b1;
                        cnt         <= '0;
                        match_cnt   <= '0;
                        tone_locked <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_period_meter.sv
// Directed self-checking bench for tone_period_meter using a small parameter set.
module tb_tone_period_meter;

    localparam int unsigned CNT_W = 10;

    logic             clk;
    logic             rst;
    logic             tone_in;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             in_band;
    logic             tone_locked;
    logic             timeout;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int n_to   = 0;
    int to_cyc = 0;
    int last_valid_cyc = 0;

    int vp[$];
    int vi[$];
    int vl[$];
    int ep[$];
    int ei[$];
    int el[$];

    tone_period_meter #(
        .CNT_W(CNT_W),
        .TIMEOUT(1000),
        .TARGET_PERIOD(100),
        .TOL(2),
        .LOCK_COUNT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tone_in(tone_in),
        .period(period),
        .period_valid(period_valid),
        .in_band(in_band),
        .tone_locked(tone_locked),
        .timeout(timeout)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Record every valid pulse and timeout pulse, sampled on the falling edge
    always @(negedge clk) begin
        if (period_valid) begin
            vp.push_back(int'(period));
            vi.push_back(int'(in_band));
            vl.push_back(int'(tone_locked));
            last_valid_cyc = cyc;
        end
        if (timeout) begin
            n_to   = n_to + 1;
            to_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic clear_rec();
        vp.delete(); vi.delete(); vl.delete();
        ep.delete(); ei.delete(); el.delete();
    endtask

    task automatic expect_v(input int p, input int i, input int l);
        ep.push_back(p); ei.push_back(i); el.push_back(l);
    endtask

    task automatic check_valids(input string tag);
        chk($sformatf("%s.count", tag), vp.size(), ep.size());
        for (int k = 0; k < ep.size(); k++) begin
            if (k < vp.size()) begin
                chk($sformatf("%s[%0d].period", tag, k), vp[k], ep[k]);
                chk($sformatf("%s[%0d].in_band", tag, k), vi[k], ei[k]);
                chk($sformatf("%s[%0d].locked", tag, k), vl[k], el[k]);
            end else begin
                chk($sformatf("%s[%0d].missing", tag, k), -1, ep[k]);
            end
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        chk({tag, ".period"}, int'(period), 0);
        chk({tag, ".period_valid"}, int'(period_valid), 0);
        chk({tag, ".in_band"}, int'(in_band), 0);
        chk({tag, ".tone_locked"}, int'(tone_locked), 0);
        chk({tag, ".timeout"}, int'(timeout), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic idle(input int n);
        tone_in = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One square-wave period of p cycles, starting with the rising edge
    task automatic run(input int p);
        tone_in = 1'b1;
        repeat (p / 2) @(posedge clk);
        #1 tone_in = 1'b0;
        repeat (p - p / 2) @(posedge clk);
        #1;
    endtask

    // 100-cycle period with a g-cycle high glitch 20 cycles into the low phase
    task automatic run_glitch(input int g);
        tone_in = 1'b1;
        repeat (50) @(posedge clk);
        #1 tone_in = 1'b0;
        repeat (20) @(posedge clk);
        #1 tone_in = 1'b1;
        repeat (g) @(posedge clk);
        #1 tone_in = 1'b0;
        repeat (30 - g) @(posedge clk);
        #1;
    endtask

    // A lone rising edge followed by a return low
    task automatic edge_only();
        tone_in = 1'b1;
        repeat (10) @(posedge clk);
        #1 tone_in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        int to_before;
        int nv_before;

        rst     = 1'b1;
        tone_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_idle("reset");

        // Lock on a clean 100-cycle tone
        clear_rec();
        idle(10);
        repeat (5) run(100);
        idle(5);
        expect_v(100, 1, 0); expect_v(100, 1, 0);
        expect_v(100, 1, 0); expect_v(100, 1, 1);
        check_valids("lock");

        // Tolerance boundaries
        reset_dut();
        clear_rec();
        idle(10);
        run(98); run(102); run(97); run(103);
        edge_only();
        expect_v(98, 1, 0); expect_v(102, 1, 0);
        expect_v(97, 0, 0); expect_v(103, 0, 0);
        check_valids("tol");

        // Loss of lock on a single out-of-band period, then relock
        reset_dut();
        clear_rec();
        idle(10);
        repeat (5) run(100);
        run(110);
        repeat (4) run(100);
        edge_only();
        expect_v(100, 1, 0); expect_v(100, 1, 0); expect_v(100, 1, 0);
        expect_v(100, 1, 1); expect_v(100, 1, 1);
        expect_v(110, 0, 0);
        expect_v(100, 1, 0); expect_v(100, 1, 0); expect_v(100, 1, 0);
        expect_v(100, 1, 1);
        check_valids("unlock");

        // Timeout after lock: hold the input low
        to_before = n_to;
        idle(1100);
        @(negedge clk);
        chk("timeout.count", n_to - to_before, 1);
        chk("timeout.delay", to_cyc - last_valid_cyc, 1000);
        chk("timeout.locked", int'(tone_locked), 0);
        chk("timeout.period_hold", int'(period), 100);
        chk("timeout.in_band_hold", int'(in_band), 1);
        @(posedge clk);
        #1;
        nv_before = vp.size();
        edge_only();
        idle(20);
        chk("timeout.rearm_no_valid", vp.size() - nv_before, 0);

        // Reset 40 cycles into a period
        reset_dut();
        clear_rec();
        idle(10);
        run(100);
        run(100);
        tone_in = 1'b1;
        repeat (40) @(posedge clk);
        #1 tone_in = 1'b0;
        chk("midrst.pre_valids", vp.size(), 2);
        reset_dut();
        check_idle("midrst");
        clear_rec();
        idle(10);
        run(101);
        run(99);
        edge_only();
        expect_v(101, 1, 0); expect_v(99, 1, 0);
        check_valids("midrst");

        // Glitches inside the low phase
        reset_dut();
        clear_rec();
        idle(10);
        run_glitch(1); run_glitch(2); run_glitch(1); run_glitch(2); run_glitch(1);
        edge_only();
`ifdef TONE_DEGLITCH_EN
        expect_v(100, 1, 0); expect_v(100, 1, 0); expect_v(100, 1, 0);
        expect_v(100, 1, 1); expect_v(100, 1, 1);
`else
        for (int k = 0; k < 5; k++) begin
            expect_v(70, 0, 0);
            expect_v(30, 0, 0);
        end
`endif
        check_valids("glitch");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tone_period_meter.md
Name: tone_period_meter

Overview:
- Receive-side counterpart to the speaker square-wave tone generators: measures the period of an incoming square-wave tone.
- Input comes from a comparator or from another board's spkp pin.
- Reports the period in clock cycles and flags whether it matches a target note within tolerance.
- Sits behind the PLL-derived clk, alongside the beep/tune blocks, for loopback self-test and tone detection.

Parameters:
CNT_W, 20, width of the period counter and the period output
TIMEOUT, 1048575, cycles without a rising edge before the measurement is abandoned; must be < 2^CNT_W
TARGET_PERIOD, 56818, expected period in clk cycles (25 MHz / 440 Hz)
TOL, 568, allowed absolute deviation from TARGET_PERIOD, inclusive
LOCK_COUNT, 4, consecutive in-band periods required to assert tone_locked; must be >= 1

Ports:
clk  input  1  system clock (PLL output, 25 MHz nominal)
rst  input  1  synchronous, active-high reset
tone_in  input  1  asynchronous square-wave tone input
period  output  CNT_W  last measured period, in clk cycles
period_valid  output  1  one-cycle pulse when period is updated
in_band  output  1  |period - TARGET_PERIOD| <= TOL; qualifies the current period value
tone_locked  output  1  LOCK_COUNT consecutive in-band periods seen
timeout  output  1  one-cycle pulse when TIMEOUT expires with no edge

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset state: all outputs 0; sync/edge flops 0; cnt 0; match_cnt 0; state IDLE. A reset mid-measurement discards the partial count, and the first edge after reset only arms the block.
- Input path: 2-flop synchronizer followed by a prev flop. rise = sync2 & ~prev.
  - rise is asserted 3 clk edges after the edge that first samples tone_in high.
- FSM state IDLE: cnt held at 0.
  - On rise: cnt <= 1, go to MEASURE.
  - No period_valid is produced.
- FSM state MEASURE: cnt increments by 1 per cycle.
  - On rise: period <= cnt, period_valid <= 1 for one cycle, cnt <= 1, stay in MEASURE.
  - So period equals the exact number of clk cycles between consecutive rise pulses.
- Timeout: in MEASURE, with cnt == TIMEOUT and no rise:
  - timeout pulses for one cycle and the FSM goes to IDLE;
  - match_cnt <= 0 and tone_locked <= 0;
  - period and in_band hold their last values.
- Simultaneous rise and cnt == TIMEOUT: rise wins. period = TIMEOUT is reported and no timeout pulse is produced.
- cnt never wraps; TIMEOUT bounds it.
- in_band: registered on the same edge as period, computed from cnt. The subtraction is done at CNT_W+1 bits, signed, with no overflow.
- match_cnt (clog2(LOCK_COUNT+1) bits), updated only on a period_valid cycle:
  - in-band: saturating increment up to LOCK_COUNT;
  - out-of-band: reset to 0.
- tone_locked: registered.
  - Asserts on the same cycle as the period_valid of the LOCK_COUNT-th consecutive in-band period.
  - Deasserts on the same cycle as the period_valid of the first out-of-band period, or with the timeout pulse.
- Edge direction: only rising edges are measured, so duty cycle is irrelevant.

Optional Feature:
- Macro: TONE_DEGLITCH_EN.
- Defined:
  - A 3-sample stability filter sits between sync2 and prev. The filtered level changes only after sync2 holds the new value for 3 consecutive cycles.
  - Pulses of 1–2 cycles are ignored.
  - rise latency becomes 6 clk edges after first sample.
  - Periods are still exact, because both edges see equal delay.
- Undefined: no filter. Latency is 3 edges, and every synchronized edge counts, including glitches.

Test Plan:
- Sim override for all scenarios: CNT_W=10, TIMEOUT=1000, TARGET_PERIOD=100, TOL=2, LOCK_COUNT=4.
- Lock on in-band tone: after reset, square wave of period 100 (50 high/50 low) → first period_valid on the 2nd rising edge with period=100; in_band=1 on every pulse; tone_locked=1 on the 4th valid pulse (5th edge).
- Tolerance boundaries: periods 98, 102, 97, 103 in sequence → in_band = 1, 1, 0, 0; match_cnt resets on 97, so tone_locked stays 0.
- Loss of lock on out-of-band period: lock at period 100, then one period of 110 → that valid pulse has period=110, in_band=0, tone_locked=0; relock requires 4 more in-band periods.
- Timeout: lock, then hold tone_in low → timeout pulses exactly once, 1000 cycles after the cnt<=1 edge; tone_locked=0; period holds 100; the next edge produces no period_valid.
- Reset mid-measurement: assert rst 40 cycles into a period → outputs 0; the next rising edge arms only; the following edge reports the correct period.
- With TONE_DEGLITCH_EN: 1- and 2-cycle high glitches inside a 100-cycle tone → period stays 100 and lock is held. Without the macro, the same stimulus produces short out-of-band periods and tone_locked=0.
